spm_banked_mem_wrapper: RTL

SPM_BANKED_MEM_WRAPPER -- requirements
Module: spm_banked_mem_wrapper

---
 rtl/spm_banked_mem_wrapper.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spm_banked_mem_wrapper.sv
// Banked scratchpad: NumBanks word-interleaved single-port SRAM banks with per-bank
// sleep/wake control and a fixed-latency, in-order read response path.
module spm_banked_mem_wrapper #(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned NumBanks    = 4,
  parameter int unsigned Latency     = 1,
  parameter int unsigned WakeCycles  = 4,
  parameter              SimInit     = "none",
  parameter int unsigned PrintSimCfg = 0,
  parameter type         impl_in_t   = logic,
  parameter type         impl_out_t  = logic,
  localparam int unsigned AddrWidth  = $clog2(NumWords),
  localparam int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned BankSel    = $clog2(NumBanks)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  impl_in_t             impl_i,
  output impl_out_t            impl_o [NumBanks],
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [NumBanks-1:0]  sleep_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [NumBanks-1:0]  bank_awake_o
);

  localparam int unsigned BankWords = NumWords / NumBanks;
  localparam int unsigned RowWidth  = AddrWidth - BankSel;
  localparam int unsigned SelWidth  = (BankSel > 0) ? BankSel : 1;
  localparam int unsigned StageCnt  = Latency - 1;
  localparam logic [3:0]  WakeLoad  = 4'(WakeCycles - 1);

  typedef enum logic [1:0] {
    BankActive,
    BankSleep,
    BankWaking
  } bank_state_e;

  logic [SelWidth-1:0]                 bank_sel;
  logic [RowWidth-1:0]                 row;
  logic [NumBanks-1:0]                 bank_active;
  logic [NumBanks-1:0]                 bank_hit;
  logic [NumBanks-1:0]                 bank_req;
  logic [NumBanks-1:0][DataWidth-1:0]  bank_rdata;
  logic [DataWidth-1:0]                wmask;
  logic                                accept;
  logic                                rd_accept;

  if (BankSel > 0) begin : g_sel
    assign bank_sel = addr_i[BankSel-1:0];
  end else begin : g_nosel
    assign bank_sel = '0;
  end
  assign row = addr_i[AddrWidth-1:BankSel];

  // Behavioural banks start uninitialised; preload and config printing live in the
  // vendor macro that replaces them.
  if (PrintSimCfg != 0 || SimInit != "none") begin : g_sim_cfg
  end

  assign req_ready_o  = bank_active[bank_sel];
  assign accept       = req_valid_i & req_ready_o;
  assign rd_accept    = accept & ~we_i;
  assign bank_awake_o = bank_active;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      wmask[i] = be_i[i / ByteWidth];
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    bank_state_e          state_q, state_d;
    logic [3:0]           wake_cnt_q, wake_cnt_d;
    logic [DataWidth-1:0] mem_q [BankWords];
    logic [DataWidth-1:0] rdata_q;

    assign bank_hit[b]    = req_valid_i && (bank_sel == SelWidth'(b));
    assign bank_req[b]    = bank_hit[b] && bank_active[b];
    assign bank_active[b] = (state_q == BankActive);
    assign bank_rdata[b]  = rdata_q;
    assign impl_o[b]      = impl_out_t'(impl_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= BankActive;
        wake_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        wake_cnt_q <= wake_cnt_d;
      end
    end

    // An accept in the same cycle defers sleep; a hit on a sleeping bank auto-wakes it.
    always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      unique case (state_q)
        BankActive: if (sleep_i[b] && !bank_req[b]) state_d = BankSleep;
        BankSleep: begin
          if (!sleep_i[b] || bank_hit[b]) begin
            state_d    = BankWaking;
            wake_cnt_d = WakeLoad;
          end
        end
        BankWaking: begin
          if (wake_cnt_q == '0) state_d = BankActive;
          else                  wake_cnt_d = wake_cnt_q - 1'b1;
        end
        default: state_d = BankActive;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (bank_req[b]) begin
        if (we_i) mem_q[row] <= (mem_q[row] & ~wmask) | (wdata_i & wmask);
        else      rdata_q    <= mem_q[row];
      end
    end
  end

  logic                 s0_valid_q;
  logic [SelWidth-1:0]  s0_sel_q;
  logic [DataWidth-1:0] s0_data;
  logic                 out_valid;
  logic [DataWidth-1:0] out_data;
  logic [DataWidth-1:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q <= 1'b0;
      s0_sel_q   <= '0;
    end else begin
      s0_valid_q <= rd_accept;
      if (rd_accept) s0_sel_q <= bank_sel;
    end
  end
  assign s0_data = bank_rdata[s0_sel_q];

  if (StageCnt > 0) begin : g_pipe
    logic [StageCnt-1:0]                pipe_valid_q;
    logic [StageCnt-1:0][DataWidth-1:0] pipe_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_valid_q <= '0;
        pipe_data_q  <= '0;
      end else begin
        pipe_valid_q[0] <= s0_valid_q;
        if (s0_valid_q) pipe_data_q[0] <= s0_data;
        for (int unsigned i = 1; i < StageCnt; i++) begin
          pipe_valid_q[i] <= pipe_valid_q[i-1];
          if (pipe_valid_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
        end
      end
    end
    assign out_valid = pipe_valid_q[StageCnt-1];
    assign out_data  = pipe_data_q[StageCnt-1];
  end else begin : g_nopipe
    assign out_valid = s0_valid_q;
    assign out_data  = s0_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        hold_q <= '0;
    else if (out_valid) hold_q <= out_data;
  end

  assign rsp_valid_o = out_valid;
  assign rdata_o     = out_valid ? out_data : hold_q;

endmodule
